// File: rtl/acs_pm_array.sv
// -----------------------------------------------------------------------------
// acs_pm_array
//   Add-compare-select stage of a hard-decision rate-1/2 Viterbi decoder.
//   For every accepted received pair it computes the 2-bit Hamming branch
//   metrics, updates all 2^(K-1) path metrics, and emits one survivor decision
//   bit per state. It also reports the state with the lowest metric (lowest
//   index on a tie) one cycle later.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      rx_pair valid this cycle
//   frame_start  in   1      (with in_valid) restart from the init metrics
//   rx_pair      in   2      hard-decision pair {c0,c1}
//   dec_valid    out  1      dec_out/dec_idx valid
//   dec_out      out  NS     survivor bit per state (1 = odd predecessor)
//   dec_idx      out  16     symbol index of dec_out within the frame
//   best_valid   out  1      best_state/best_pm valid
//   best_state   out  K-1    argmin of the path metrics
//   best_pm      out  PM_W   metric of best_state
//   norm_evt     out  1      normalisation applied on this update
// -----------------------------------------------------------------------------
module acs_pm_array #(
    parameter int unsigned K       = 7,
    parameter int unsigned G0      = 'o171,
    parameter int unsigned G1      = 'o133,
    parameter int unsigned PM_W    = 7,
    parameter int unsigned INIT_PM = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    frame_start,
    input  logic [1:0]              rx_pair,
    output logic                    dec_valid,
    output logic [2**(K-1)-1:0]     dec_out,
    output logic [15:0]             dec_idx,
    output logic                    best_valid,
    output logic [K-2:0]            best_state,
    output logic [PM_W-1:0]         best_pm,
    output logic                    norm_evt
);

    localparam int unsigned NS = 2**(K-1);
    localparam int unsigned SW = K-1;

    logic [PM_W-1:0] pm     [NS];
    logic [PM_W-1:0] opnd   [NS];
    logic [PM_W-1:0] pm_nxt [NS];
    logic [NS-1:0]   dec_nxt;
    logic [NS-1:0]   msb_vec;
    logic            use_init;
    logic            do_norm;
    logic [15:0]     idx_cnt;
    logic [15:0]     idx_base;
    logic [SW-1:0]   arg_state;
    logic [PM_W-1:0] arg_pm;

    function automatic logic [PM_W-1:0] init_pm(input int unsigned s);
        return (s == 0) ? '0 : PM_W'(INIT_PM);
    endfunction

    // Hamming distance between the received pair and the code bits produced
    // by encoder register contents r = {u, s}.
    function automatic logic [1:0] branch_metric(input logic [K-1:0] r,
                                                 input logic [1:0]   rx);
        logic [1:0] c;
        logic [1:0] d;
        c = {^(r & K'(G0)), ^(r & K'(G1))};
        d = rx ^ c;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    // Operand selection: init vector on frame start, otherwise registered
    // metrics, with the common MSB stripped once every metric has it set.
    always_comb begin
        for (int unsigned s = 0; s < NS; s++) begin
            msb_vec[s] = pm[s][PM_W-1];
        end
        use_init = in_valid & frame_start;
        do_norm  = in_valid & ~frame_start & (&msb_vec);
        for (int unsigned s = 0; s < NS; s++) begin
            if (use_init) begin
                opnd[s] = init_pm(s);
            end else if (do_norm) begin
                opnd[s] = {1'b0, pm[s][PM_W-2:0]};
            end else begin
                opnd[s] = pm[s];
            end
        end
    end

    // ACS butterfly per next state; ties keep the even predecessor.
    always_comb begin
        logic [SW-1:0]   nsv;
        logic [SW-1:0]   p0;
        logic [SW-1:0]   p1;
        logic [PM_W-1:0] a;
        logic [PM_W-1:0] b;
        for (int unsigned ns = 0; ns < NS; ns++) begin
            nsv = SW'(ns);
            p0  = {nsv[SW-2:0], 1'b0};
            p1  = {nsv[SW-2:0], 1'b1};
            a   = opnd[p0] + PM_W'(branch_metric({nsv[SW-1], p0}, rx_pair));
            b   = opnd[p1] + PM_W'(branch_metric({nsv[SW-1], p1}, rx_pair));
            dec_nxt[ns] = (b < a);
            pm_nxt[ns]  = (b < a) ? b : a;
        end
    end

    // Argmin over registered metrics, lowest index wins ties.
    always_comb begin
        arg_state = '0;
        arg_pm    = pm[0];
        for (int unsigned s = 1; s < NS; s++) begin
            if (pm[s] < arg_pm) begin
                arg_state = SW'(s);
                arg_pm    = pm[s];
            end
        end
    end

    assign idx_base = frame_start ? '0 : idx_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NS; s++) begin
                pm[s] <= init_pm(s);
            end
            dec_valid  <= 1'b0;
            dec_out    <= '0;
            dec_idx    <= '0;
            idx_cnt    <= '0;
            norm_evt   <= 1'b0;
            best_valid <= 1'b0;
            best_state <= '0;
            best_pm    <= '0;
        end else begin
            dec_valid  <= in_valid;
            norm_evt   <= do_norm;
            best_valid <= dec_valid;
            if (in_valid) begin
                for (int unsigned s = 0; s < NS; s++) begin
                    pm[s] <= pm_nxt[s];
                end
                dec_out <= dec_nxt;
                dec_idx <= idx_base;
                idx_cnt <= idx_base + 16'd1;
            end
            // pm has just been refreshed whenever dec_valid is high.
            if (dec_valid) begin
                best_state <= arg_state;
                best_pm    <= arg_pm;
            end
        end
    end

endmodule

// File: tb/tb_acs_pm_array.sv
module tb_acs_pm_array;

    localparam int NS      = 64;
    localparam int INIT_PM = 32;
    localparam int GA      = 'o171;
    localparam int GB      = 'o133;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        frame_start;
    logic [1:0]  rx_pair;
    logic        dec_valid;
    logic [63:0] dec_out;
    logic [15:0] dec_idx;
    logic        best_valid;
    logic [5:0]  best_state;
    logic [6:0]  best_pm;
    logic        norm_evt;

    acs_pm_array #(.K(7), .G0('o171), .G1('o133), .PM_W(7), .INIT_PM(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
        .rx_pair(rx_pair), .dec_valid(dec_valid), .dec_out(dec_out), .dec_idx(dec_idx),
        .best_valid(best_valid), .best_state(best_state), .best_pm(best_pm),
        .norm_evt(norm_evt)
    );

    always #5 clk = ~clk;

    // Reference: unbounded metrics; hardware value = metric - offset.
    longint      mpm [NS];
    longint      offset;
    int          midx;
    logic [63:0] last_dec;
    logic [15:0] last_idx;
    bit          prev_valid;
    int          n_vec;
    int          n_bad;
    int          norm_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int parity(input int x);
        return $countones(x) & 1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) mpm[s] = (s == 0) ? 0 : INIT_PM;
        offset     = 0;
        midx       = 0;
        last_dec   = '0;
        last_idx   = '0;
        prev_valid = 0;
    endtask

    task automatic model_argmin(output int st, output longint mn);
        st = 0;
        mn = mpm[0];
        for (int s = 1; s < NS; s++) if (mpm[s] < mn) begin mn = mpm[s]; st = s; end
    endtask

    // Forward trellis walk: each (state, input) branch competes for its
    // successor; the even predecessor is visited first and kept on ties.
    task automatic model_step(input bit fs, input logic [1:0] rx,
                              output bit nrm, output logic [63:0] d, output logic [15:0] ix);
        longint nw [NS];
        if (fs) begin
            for (int s = 0; s < NS; s++) mpm[s] = (s == 0) ? 0 : INIT_PM;
            offset = 0;
            midx   = 0;
            nrm    = 0;
        end else begin
            nrm = 1;
            for (int s = 0; s < NS; s++) if (mpm[s] - offset < 64) nrm = 0;
            if (nrm) offset += 64;
        end
        for (int s = 0; s < NS; s++) nw[s] = 64'h7fff_ffff;
        d = '0;
        for (int s = 0; s < NS; s++) begin
            for (int u = 0; u < 2; u++) begin
                int     nxt, r, c;
                longint m;
                nxt = (u << 5) | (s >> 1);
                r   = (u << 6) | s;
                c   = parity(r & GA) * 2 + parity(r & GB);
                m   = mpm[s] + $countones(int'(rx) ^ c);
                if (m < nw[nxt]) begin
                    nw[nxt] = m;
                    d[nxt]  = s[0];
                end
            end
        end
        for (int s = 0; s < NS; s++) mpm[s] = nw[s];
        ix   = 16'(midx);
        midx = (midx + 1) % 65536;
    endtask

    // Drive one cycle, then check the outputs produced by that edge.
    task automatic step(input bit v, input bit fs, input logic [1:0] rx);
        int          bs;
        longint      bm;
        bit          nrm;
        logic [63:0] d;
        logic [15:0] ix;
        in_valid    = v;
        frame_start = fs;
        rx_pair     = rx;
        @(posedge clk);
        #1;
        check_eq("best_valid", best_valid, prev_valid);
        if (prev_valid) begin
            model_argmin(bs, bm);
            check_eq("best_state", best_state, bs);
            check_eq("best_pm", best_pm, bm - offset);
        end
        if (norm_evt) norm_cnt++;
        if (v) begin
            model_step(fs, rx, nrm, d, ix);
            check_eq("dec_valid", dec_valid, 1);
            check_eq("dec_out", dec_out, d);
            check_eq("dec_idx", dec_idx, ix);
            check_eq("norm_evt", norm_evt, nrm);
            last_dec = d;
            last_idx = ix;
        end else begin
            check_eq("idle_valid", dec_valid, 0);
            check_eq("idle_norm", norm_evt, 0);
            check_eq("hold_dec", dec_out, last_dec);
            check_eq("hold_idx", dec_idx, last_idx);
        end
        prev_valid = v;
    endtask

    // Encode msg (MSB first), feed it, optionally flipping rx_pair[1] at one symbol,
    // and recover the message by traceback over the observed decisions.
    task automatic run_codeword(input logic [9:0] msg, input int err_sym, input string tag);
        int          es;
        int          enc_hist [10];
        logic [63:0] dec_hist [10];
        logic [5:0]  st;
        logic [9:0]  rec;
        es = 0;
        for (int i = 0; i < 10; i++) begin
            int         u, r;
            logic [1:0] rx;
            u  = msg[9-i];
            r  = (u << 6) | es;
            rx = 2'(parity(r & GA) * 2 + parity(r & GB));
            if (i == err_sym) rx[1] = ~rx[1];
            es = (u << 5) | (es >> 1);
            enc_hist[i] = es;
            step(1, i == 0, rx);
            dec_hist[i] = dec_out;
            if (i > 0) begin
                check_eq({tag, "_bpm"}, best_pm, (err_sym >= 0 && i - 1 >= err_sym) ? 1 : 0);
                if (err_sym < 0) check_eq({tag, "_bst"}, best_state, enc_hist[i-1]);
            end
        end
        step(0, 0, 2'b00);
        check_eq({tag, "_bpm_last"}, best_pm, (err_sym >= 0) ? 1 : 0);
        st = best_state;
        for (int t = 9; t >= 0; t--) begin
            rec[9-t] = st[5];
            st = {st[4:0], dec_hist[t][st]};
        end
        check_eq({tag, "_msg"}, rec, msg);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; norm_cnt = 0;
        rst_n = 1'b0; in_valid = 0; frame_start = 0; rx_pair = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All-zero stream.
        for (int i = 0; i < 20; i++) begin
            step(1, i == 0, 2'b00);
            check_eq("zero_idx", dec_idx, i);
            check_eq("zero_dec0", dec_out[0], 0);
            if (i > 0) begin
                check_eq("zero_bst", best_state, 0);
                check_eq("zero_bpm", best_pm, 0);
            end
        end
        step(0, 0, 2'b00);

        // Noiseless and single-error codeword.
        run_codeword(10'b1011000000, -1, "cw");
        run_codeword(10'b1011000000, 3, "cw_err");

        // Long random stream, back-to-back, long enough for normalisation.
        norm_cnt = 0;
        for (int i = 0; i < 600; i++) step(1, i == 0, 2'($urandom_range(0, 3)));
        check_eq("norm_seen", norm_cnt > 0, 1);

        // Mid-stream frame start and idle gaps.
        for (int i = 0; i < 80; i++) begin
            if (i == 30 || i == 65) begin
                step(0, 0, 2'($urandom_range(0, 3)));
                step(0, 1, 2'($urandom_range(0, 3)));
            end
            step(1, i == 50, 2'($urandom_range(0, 3)));
            if (i == 50) check_eq("fs_idx", dec_idx, 0);
        end

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) step(1, 0, 2'($urandom_range(0, 3)));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_dec_out", dec_out, 0);
        check_eq("rst_dec_idx", dec_idx, 0);
        check_eq("rst_best_valid", best_valid, 0);
        check_eq("rst_best_state", best_state, 0);
        check_eq("rst_best_pm", best_pm, 0);
        check_eq("rst_norm", norm_evt, 0);
        check_eq("rst_pm0", dut.pm[0], 0);
        for (int s = 1; s < NS; s++) check_eq("rst_pm", dut.pm[s], INIT_PM);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // First symbols after reset, without frame_start.
        for (int i = 0; i < 12; i++) step(1, 0, 2'($urandom_range(0, 3)));
        step(0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
